// File: rtl/mem_stream_pkg.sv
// Shared types and helpers for the memory stream reader.
package mem_stream_pkg;

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    localparam int unsigned ParityMaxW = 64;

    function automatic logic even_parity(input logic [ParityMaxW-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_stream_fifo2.sv
// Two-entry FIFO carrying stream payload (data plus parity-error flag).
module mem_stream_fifo2 #(
    parameter int unsigned Width = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [Width-1:0] slot_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            if (push_i) begin
                slot_q[wr_ptr_q] <= data_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign data_o  = slot_q[rd_ptr_q];
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/mem_stream_reader.sv
// Streams count words out of a local memory starting at start_addr, with backpressure.
// Define MEM_STREAM_READER_PARITY_EN to store and check an even-parity bit per word.
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 2 ** AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_perr
);

`ifdef MEM_STREAM_READER_PARITY_EN
    localparam int unsigned MW = DW + 1;
`else
    localparam int unsigned MW = DW;
`endif

    localparam logic [AW:0] CntOne = (AW + 1)'(1);

    logic [MW-1:0] mem [DEPTH];
    logic [MW-1:0] wr_word;
    logic [MW-1:0] rd_word_q;
    logic          rd_perr;

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [AW:0]   reads_left_q;
    logic [AW:0]   beats_left_q;
    logic          done_q;
    logic          rd_vld_q;

    logic          buf_full;
    logic          buf_empty;
    logic          pop;
    logic          rd_issue;
    logic [2:0]    occ;

`ifdef MEM_STREAM_READER_PARITY_EN
    assign wr_word = {even_parity(ParityMaxW'(wr_data)), wr_data};
    assign rd_perr = even_parity(ParityMaxW'(rd_word_q[DW-1:0])) ^ rd_word_q[DW];
`else
    assign wr_word = wr_data;
    assign rd_perr = 1'b0;
`endif

    // Memory is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        rd_word_q <= mem[addr_q];
    end

    assign pop = dout_valid && dout_ready;

    // Slots committed after this edge; the beat leaving now frees its slot for a new read.
    assign occ      = {1'b0, buf_full, ~buf_empty & ~buf_full} + {2'b00, rd_vld_q}
                      - {2'b00, pop};
    assign rd_issue = (state_q == StRead) && (occ < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            reads_left_q <= '0;
            beats_left_q <= '0;
            done_q       <= 1'b0;
            rd_vld_q     <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            rd_vld_q <= rd_issue;
            if (rd_issue) begin
                addr_q       <= addr_q + AW'(1);
                reads_left_q <= reads_left_q - CntOne;
            end
            if (pop) begin
                beats_left_q <= beats_left_q - CntOne;
            end
            case (state_q)
                StIdle: begin
                    if (start && (count != '0)) begin
                        addr_q       <= start_addr;
                        reads_left_q <= count;
                        beats_left_q <= count;
                        state_q      <= StRead;
                    end
                end
                StRead: begin
                    if (rd_issue && (reads_left_q == CntOne)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (pop && (beats_left_q == CntOne)) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    mem_stream_fifo2 #(
        .Width (DW + 1)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (rd_vld_q),
        .pop_i   (pop),
        .data_i  ({rd_perr, rd_word_q[DW-1:0]}),
        .data_o  ({dout_perr, dout}),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    assign dout_valid = ~buf_empty;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;

endmodule
